// File: rtl/mips86_fetch_pkg.sv
// Shared types and constants for the MIPS86 instruction fetch path.
package mips86_fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE0,
        ISSUE1,
        CAPT,
        DONE
    } fetch_state_t;

    localparam int WORD_BYTES = 4;
    localparam int WORD_WIDTH = 32;

endpackage

// File: rtl/rom_word_fetch.sv
// Fetches one big-endian 32-bit word from the dual-port byte ROM, two bytes per
// cycle, and presents it to decode over a valid/ready handshake.
module rom_word_fetch
    import mips86_fetch_pkg::*;
#(
    parameter int BUS_WIDTH    = 8,
    parameter int SELECT_WIDTH = 32,
    parameter int MEMORY_SIZE  = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    input  logic [SELECT_WIDTH-1:0] req_addr,
    output logic                    req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WORD_WIDTH-1:0]   rsp_data,
    output logic                    rsp_err,
    output logic [SELECT_WIDTH-1:0] rom_select,
    output logic [SELECT_WIDTH-1:0] rom_selectA,
    input  logic [BUS_WIDTH-1:0]    rom_data,
    input  logic [BUS_WIDTH-1:0]    rom_dataA
);

    // Lowest start address whose last byte falls outside the ROM; comparing
    // against this avoids adding to req_addr, so huge addresses cannot wrap.
    localparam logic [SELECT_WIDTH-1:0] FIRST_BAD =
        SELECT_WIDTH'(MEMORY_SIZE - WORD_BYTES + 1);

    fetch_state_t              state, state_nxt;
    logic [SELECT_WIDTH-1:0]   addr_q;
    logic                      err_q;
    logic                      vld_q;
    logic                      bad_req;

    assign bad_req   = (req_addr[1:0] != 2'b00) || (req_addr >= FIRST_BAD);
    assign req_ready = (state == IDLE) && !rst;
    assign rsp_valid = vld_q;
    assign rsp_err   = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = bad_req ? DONE : ISSUE0;
            ISSUE0:  state_nxt = ISSUE1;
            ISSUE1:  state_nxt = CAPT;
            CAPT:    state_nxt = DONE;
            DONE:    if (vld_q && rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Selects are set one state ahead so the ROM's registered read lines up
    // with the capture states.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            err_q       <= 1'b0;
            vld_q       <= 1'b0;
            rsp_data    <= '0;
            rom_select  <= '0;
            rom_selectA <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q <= req_addr;
                        if (bad_req) begin
                            err_q    <= 1'b1;
                            rsp_data <= '0;
                        end else begin
                            rom_select  <= req_addr;
                            rom_selectA <= req_addr + SELECT_WIDTH'(1);
                        end
                    end
                end
                ISSUE0: begin
                    rom_select  <= addr_q + SELECT_WIDTH'(2);
                    rom_selectA <= addr_q + SELECT_WIDTH'(3);
                end
                ISSUE1: begin
                    rsp_data[31:24] <= rom_data;
                    rsp_data[23:16] <= rom_dataA;
                end
                CAPT: begin
                    rsp_data[15:8] <= rom_data;
                    rsp_data[7:0]  <= rom_dataA;
                    vld_q          <= 1'b1;
                end
                DONE: begin
                    // Error responses enter DONE with valid still low and raise it here.
                    if (!vld_q) begin
                        vld_q <= 1'b1;
                    end else if (rsp_ready) begin
                        vld_q <= 1'b0;
                        err_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
